// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the latch-RAM access controller: default geometry,
// FSM state codes and the fixed state sequence of one access.
package ram_access_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // Once an access has started it always walks SETUP -> STROBE -> HOLD -> IDLE.
    function automatic state_e access_step(input state_e s);
        case (s)
            ST_SETUP:  access_step = ST_STROBE;
            ST_STROBE: access_step = ST_HOLD;
            default:   access_step = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way request arbiter. Round-robin by default: on contention the port not
// served last wins. Define FIXED_PRIORITY_EN for strict port-0 priority, which
// removes the pointer flop (port 1 may then starve).
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    output logic sel,
    output logic valid
);

    assign valid = req0 | req1;

`ifdef FIXED_PRIORITY_EN
    // Port 0 wins whenever it asks; no state to keep.
    assign sel = ~req0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, rst_n, upd};
`else
    // last_q = port served most recently; reset value 1 makes port 0 preferred.
    logic last_q;
    logic last_d;

    // Single request wins outright; on contention prefer the other port.
    always_comb begin
        sel    = (req0 & req1) ? ~last_q : req1;
        last_d = upd ? sel : last_q;
    end

    // Pointer register, updated only when the controller accepts a grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: rtl/ram_access_ctrl.sv
// Two-requester controller for a latch-based RAM array. Each access is
// sequenced SETUP -> STROBE -> HOLD so address and data are stable around the
// level-sensitive write enable. Arbitration lives in rr_arb2; define
// FIXED_PRIORITY_EN for fixed port-0 priority instead of round-robin.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;   // 0 = port 0 owns the RAM
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic arb_sel;
    logic arb_valid;
    logic arb_upd;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
        .upd   (arb_upd),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    // Next-state logic: capture the winner in IDLE, sample read data in STROBE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        arb_upd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    arb_upd = 1'b1;
                    owner_d = arb_sel;
                    we_d    = arb_sel ? we1    : we0;
                    addr_d  = arb_sel ? addr1  : addr0;
                    wdata_d = arb_sel ? wdata1 : wdata0;
                    state_d = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (!we_q) begin
                    rdata_d = ram_rdata;
                end
                state_d = access_step(state_q);
            end
            default: begin
                state_d = access_step(state_q);
            end
        endcase
    end

    // State and captured-request registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode straight from registers, so they drop on the reset edge.
    assign gnt0      = (state_q != ST_IDLE) && !owner_q;
    assign gnt1      = (state_q != ST_IDLE) &&  owner_q;
    assign done0     = (state_q == ST_HOLD) && !owner_q;
    assign done1     = (state_q == ST_HOLD) &&  owner_q;
    assign ram_we    = (state_q == ST_STROBE) && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a simple latch-RAM model.
module tb_ram_access_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [16];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // RAM model: data captured while the strobe is high, asynchronous read.
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete access from an IDLE cycle; checks every phase.
    task automatic access(input int port, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic chk_rd,
                          input logic [DW-1:0] exp_rd);
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
        tick;   // SETUP
        chk("setup_gnt0",  32'(gnt0), 32'(port == 0));
        chk("setup_gnt1",  32'(gnt1), 32'(port == 1));
        chk("setup_we",    32'(ram_we), 32'(0));
        chk("setup_addr",  32'(ram_addr), 32'(a));
        chk("setup_wdata", 32'(ram_wdata), 32'(d));
        req0 = 1'b0;
        req1 = 1'b0;
        tick;   // STROBE
        chk("strobe_we",    32'(ram_we), 32'(we));
        chk("strobe_addr",  32'(ram_addr), 32'(a));
        chk("strobe_wdata", 32'(ram_wdata), 32'(d));
        chk("strobe_done",  32'({done0, done1}), 32'(0));
        tick;   // HOLD
        chk("hold_done0", 32'(done0), 32'(port == 0));
        chk("hold_done1", 32'(done1), 32'(port == 1));
        chk("hold_we",    32'(ram_we), 32'(0));
        chk("hold_addr",  32'(ram_addr), 32'(a));
        chk("hold_wdata", 32'(ram_wdata), 32'(d));
        if (chk_rd) chk("hold_rdata", 32'(rdata), 32'(exp_rd));
        tick;   // IDLE
        chk("idle_gnt",  32'({gnt0, gnt1}), 32'(0));
        chk("idle_done", 32'({done0, done1}), 32'(0));
    endtask

    initial begin
        logic exp0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset held two cycles with a pending request.
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 8'hA5;
        tick;
        chk("rst_outs", 32'({gnt0, gnt1, done0, done1, ram_we}), 32'(0));
        chk("rst_addr", 32'(ram_addr), 32'(0));
        chk("rst_wdata", 32'(ram_wdata), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        tick;
        chk("rst2_gnt0", 32'(gnt0), 32'(0));
        rst_n = 1'b1;
        chk("rel_gnt0", 32'(gnt0), 32'(0));

        // Write then read on port 0.
        access(0, 1'b1, 4'h3, 8'hA5, 1'b0, 8'h00);
        access(0, 1'b0, 4'h3, 8'h00, 1'b1, 8'hA5);

        // Port 1 at the top address; rdata must hold across a write.
        access(1, 1'b1, 4'hF, 8'h5A, 1'b0, 8'h00);
        chk("rdata_held", 32'(rdata), 32'(8'hA5));
        access(1, 1'b0, 4'hF, 8'h00, 1'b1, 8'h5A);

        // Contention: port 1 served last, so port 0 goes first.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h1; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'h2; wdata1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
`ifdef FIXED_PRIORITY_EN
            exp0 = 1'b1;
`else
            exp0 = (i % 2 == 0);
`endif
            tick;
            chk("cont_gnt0", 32'(gnt0), 32'(exp0));
            chk("cont_gnt1", 32'(gnt1), 32'(!exp0));
            chk("cont_addr", 32'(ram_addr), exp0 ? 32'h1 : 32'h2);
            tick;
            chk("cont_we", 32'(ram_we), 32'(1));
            tick;
            chk("cont_done0", 32'(done0), 32'(exp0));
            chk("cont_done1", 32'(done1), 32'(!exp0));
            tick;
            chk("cont_idle", 32'({gnt0, gnt1}), 32'(0));
        end
        req0 = 1'b0; req1 = 1'b0;

        // Abort a write in its STROBE cycle.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h5; wdata0 = 8'hC3;
        tick;
        req0 = 1'b0;
        tick;
        chk("abort_strobe", 32'(ram_we), 32'(1));
        rst_n = 1'b0;
        tick;
        chk("abort_we",   32'(ram_we), 32'(0));
        chk("abort_gnt",  32'({gnt0, gnt1}), 32'(0));
        chk("abort_done", 32'({done0, done1}), 32'(0));
        chk("abort_addr", 32'(ram_addr), 32'(0));
        rst_n = 1'b1;
        tick;
        chk("abort_nodone1", 32'({done0, done1}), 32'(0));
        tick;
        chk("abort_nodone2", 32'({done0, done1, gnt0, gnt1}), 32'(0));

        // Withdraw: port 1 pulses for one cycle while port 0 is busy.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h6; wdata0 = 8'h66;
        tick;
        chk("wd_gnt0", 32'(gnt0), 32'(1));
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'h7; wdata1 = 8'h77;
        tick;
        req1 = 1'b0;
        chk("wd_gnt1_a", 32'(gnt1), 32'(0));
        tick;
        chk("wd_done0", 32'(done0), 32'(1));
        chk("wd_done1_a", 32'(done1), 32'(0));
        tick;
        chk("wd_gnt1_b", 32'(gnt1), 32'(0));
        tick;
        chk("wd_gnt1_c", 32'({gnt1, done1}), 32'(0));
        chk("wd_idle_addr", 32'(ram_addr), 32'(4'h6));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
